// File: rtl/snn_lif_neuron_array.sv
// Leaky integrate-and-fire neuron array: masked integration, timestep fire/leak/refractory,
// per-neuron spike counts and an argmax winner reported at picture end.
module snn_lif_neuron_array #(
   parameter int NUM_NEURONS = 16,
   parameter int POT_W       = 16,
   parameter int STIM_W      = 16,
   parameter int REFRAC_W    = 4,
   parameter int CNT_W       = 8,
   parameter int IDX_W       = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [STIM_W-1:0]   stimuli,
   input  logic [NUM_NEURONS-1:0]     connection,
   input  logic                       enable,
   input  logic                       step_done,
   input  logic                       picture_done,
   input  logic signed [POT_W-1:0]    threshold,
   input  logic [POT_W-2:0]           leak,
   input  logic [REFRAC_W-1:0]        refrac_period,
   input  logic                       reset_mode,
   output logic [NUM_NEURONS-1:0]     spike_o,
   output logic                       spike_valid,
   output logic [IDX_W-1:0]           winner_o,
   output logic                       winner_valid
);

   localparam logic signed [POT_W:0] POT_MAX = {2'b00, {(POT_W-1){1'b1}}};
   localparam logic signed [POT_W:0] POT_MIN = {2'b11, {(POT_W-1){1'b0}}};

   logic signed [POT_W-1:0]  pot_q    [NUM_NEURONS];
   logic signed [POT_W-1:0]  pot_d    [NUM_NEURONS];
   logic [REFRAC_W-1:0]      refrac_q [NUM_NEURONS];
   logic [REFRAC_W-1:0]      refrac_d [NUM_NEURONS];
   logic [CNT_W-1:0]         cnt_q    [NUM_NEURONS];
   logic [CNT_W-1:0]         cnt_d    [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]   spike_q, spike_d;
   logic                     spike_valid_q, spike_valid_d;
   logic [IDX_W-1:0]         winner_q, winner_d;
   logic                     winner_valid_q, winner_valid_d;

   logic signed [POT_W:0]    stim_ext;
   logic signed [POT_W:0]    thr_ext;
   logic [IDX_W-1:0]         best_idx;
   logic [CNT_W-1:0]         best_cnt;

   // All arithmetic is done one bit wider, then clamped back to POT_W.
   function automatic logic signed [POT_W-1:0] sat(input logic signed [POT_W:0] v);
      if (v > POT_MAX)
         return POT_MAX[POT_W-1:0];
      else if (v < POT_MIN)
         return POT_MIN[POT_W-1:0];
      else
         return v[POT_W-1:0];
   endfunction

   function automatic logic signed [POT_W-1:0] leak_step(input logic signed [POT_W-1:0] p,
                                                         input logic [POT_W-2:0] lk);
      logic signed [POT_W:0] p_ext, mag, lk_ext, r;
      p_ext  = {p[POT_W-1], p};
      lk_ext = {2'b00, lk};
      mag    = p_ext[POT_W] ? -p_ext : p_ext;
      r      = p_ext[POT_W] ? (p_ext + lk_ext) : (p_ext - lk_ext);
      if (mag <= lk_ext)
         return '0;
      else
         return r[POT_W-1:0];
   endfunction

   assign stim_ext = {{(POT_W-STIM_W+1){stimuli[STIM_W-1]}}, stimuli};
   assign thr_ext  = {threshold[POT_W-1], threshold};

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_idx = '0;
      best_cnt = cnt_q[0];
      for (int i = 1; i < NUM_NEURONS; i++) begin
         if (cnt_q[i] > best_cnt) begin
            best_cnt = cnt_q[i];
            best_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      pot_d          = pot_q;
      refrac_d       = refrac_q;
      cnt_d          = cnt_q;
      spike_d        = '0;
      spike_valid_d  = 1'b0;
      winner_d       = winner_q;
      winner_valid_d = 1'b0;
      if (picture_done) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_d[i]    = '0;
            refrac_d[i] = '0;
            cnt_d[i]    = '0;
         end
         winner_d       = best_idx;
         winner_valid_d = 1'b1;
      end else if (step_done) begin
         spike_valid_d = 1'b1;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (refrac_q[i] != '0) begin
               refrac_d[i] = refrac_q[i] - REFRAC_W'(1);
            end else if (pot_q[i] >= threshold) begin
               spike_d[i]  = 1'b1;
               refrac_d[i] = refrac_period;
               if (cnt_q[i] != {CNT_W{1'b1}})
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               pot_d[i] = reset_mode ? sat({pot_q[i][POT_W-1], pot_q[i]} - thr_ext) : '0;
            end else begin
               pot_d[i] = leak_step(pot_q[i], leak);
            end
         end
      end else if (enable) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (connection[i] && refrac_q[i] == '0)
               pot_d[i] = sat({pot_q[i][POT_W-1], pot_q[i]} + stim_ext);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_q[i]    <= '0;
            refrac_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         spike_q        <= '0;
         spike_valid_q  <= 1'b0;
         winner_q       <= '0;
         winner_valid_q <= 1'b0;
      end else begin
         pot_q          <= pot_d;
         refrac_q       <= refrac_d;
         cnt_q          <= cnt_d;
         spike_q        <= spike_d;
         spike_valid_q  <= spike_valid_d;
         winner_q       <= winner_d;
         winner_valid_q <= winner_valid_d;
      end
   end

   assign spike_o      = spike_q;
   assign spike_valid  = spike_valid_q;
   assign winner_o     = winner_q;
   assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_snn_lif_neuron_array.sv
// Directed bench for snn_lif_neuron_array with an integer-arithmetic reference model
// compared against outputs and neuron state on every falling edge.
module tb_snn_lif_neuron_array;

   localparam int N = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] stimuli;
   logic [N-1:0]       connection;
   logic               enable, step_done, picture_done;
   logic signed [15:0] threshold;
   logic [14:0]        leak;
   logic [3:0]         refrac_period;
   logic               reset_mode;
   logic [N-1:0]       spike_o;
   logic               spike_valid;
   logic [3:0]         winner_o;
   logic               winner_valid;

   int errors = 0;
   int checks = 0;

   int     m_pot [N];
   int     m_ref [N];
   int     m_cnt [N];
   int     m_spike;
   int     m_sv, m_win, m_wv;

   snn_lif_neuron_array dut (
      .clk(clk), .rst(rst), .stimuli(stimuli), .connection(connection),
      .enable(enable), .step_done(step_done), .picture_done(picture_done),
      .threshold(threshold), .leak(leak), .refrac_period(refrac_period),
      .reset_mode(reset_mode), .spike_o(spike_o), .spike_valid(spike_valid),
      .winner_o(winner_o), .winner_valid(winner_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int pot(input int i);
      return int'(dut.pot_q[i]);
   endfunction

   function automatic int rfr(input int i);
      return int'(dut.refrac_q[i]);
   endfunction

   function automatic int cnt(input int i);
      return int'(dut.cnt_q[i]);
   endfunction

   function automatic int clamp(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference model: plain integer arithmetic straight from the neuron rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_pot[i] = 0; m_ref[i] = 0; m_cnt[i] = 0;
         end
         m_spike = 0; m_sv = 0; m_win = 0; m_wv = 0;
      end else begin
         m_spike = 0; m_sv = 0; m_wv = 0;
         if (picture_done) begin
            int best;
            best = 0;
            for (int i = 0; i < N; i++)
               if (m_cnt[i] > m_cnt[best]) best = i;
            m_win = best; m_wv = 1;
            for (int i = 0; i < N; i++) begin
               m_pot[i] = 0; m_ref[i] = 0; m_cnt[i] = 0;
            end
         end else if (step_done) begin
            m_sv = 1;
            for (int i = 0; i < N; i++) begin
               if (m_ref[i] > 0) begin
                  m_ref[i] = m_ref[i] - 1;
               end else if (m_pot[i] >= int'(threshold)) begin
                  m_spike = m_spike | (1 << i);
                  m_ref[i] = int'(refrac_period);
                  if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
                  m_pot[i] = reset_mode ? clamp(m_pot[i] - int'(threshold)) : 0;
               end else begin
                  int a;
                  a = (m_pot[i] < 0) ? -m_pot[i] : m_pot[i];
                  if (a <= int'(leak)) m_pot[i] = 0;
                  else if (m_pot[i] > 0) m_pot[i] = m_pot[i] - int'(leak);
                  else m_pot[i] = m_pot[i] + int'(leak);
               end
            end
         end else if (enable) begin
            for (int i = 0; i < N; i++)
               if (connection[i] && m_ref[i] == 0)
                  m_pot[i] = clamp(m_pot[i] + int'(stimuli));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         int bad;
         check("spike_o", spike_o, m_spike);
         check("spike_valid", spike_valid, m_sv);
         check("winner_o", winner_o, m_win);
         check("winner_valid", winner_valid, m_wv);
         bad = -1;
         for (int i = N - 1; i >= 0; i--)
            if (pot(i) != m_pot[i] || rfr(i) != m_ref[i] || cnt(i) != m_cnt[i]) bad = i;
         check("state_first_bad_neuron", bad, -1);
      end
   end

   task automatic drive(input logic en, input logic signed [15:0] s, input logic [N-1:0] c,
                        input logic sd, input logic pd);
      enable = en; stimuli = s; connection = c; step_done = sd; picture_done = pd;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 16'sd0, '0, 1'b0, 1'b0);
   endtask

   task automatic step();
      drive(1'b0, 16'sd0, '0, 1'b1, 1'b0);
   endtask

   task automatic pic();
      drive(1'b0, 16'sd0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; enable = 0; stimuli = 0; connection = '0; step_done = 0; picture_done = 0;
      threshold = 16'sd100; leak = '0; refrac_period = '0; reset_mode = 1'b0;
      #12;
      check("reset_spike_o", spike_o, 0);
      check("reset_spike_valid", spike_valid, 0);
      check("reset_winner_valid", winner_valid, 0);
      check("reset_pot0", pot(0), 0);
      @(negedge clk);
      rst = 1'b0;

      // Integrate and fire, reset to zero then subtract mode
      repeat (3) drive(1'b1, 16'sd40, 16'h0001, 1'b0, 1'b0);
      step();
      check("fire_spike_o", spike_o, 16'h0001);
      check("fire_spike_valid", spike_valid, 1);
      check("fire_pot0_rm0", pot(0), 0);
      idle();
      check("fire_valid_drops", spike_valid, 0);
      reset_mode = 1'b1;
      repeat (3) drive(1'b1, 16'sd40, 16'h0001, 1'b0, 1'b0);
      step();
      check("fire_spike_o_rm1", spike_o, 16'h0001);
      check("fire_pot0_rm1", pot(0), 20);
      idle();
      pic();
      check("pic1_winner_valid", winner_valid, 1);
      check("pic1_winner", winner_o, 0);
      idle();
      check("pic1_winner_valid_drops", winner_valid, 0);

      // Leak toward zero from both signs
      reset_mode = 1'b0; leak = 15'd5;
      drive(1'b1, 16'sd7, 16'h0001, 1'b0, 1'b0);
      check("leak_pot_pos", pot(0), 7);
      step();
      check("leak_pos_1", pot(0), 2);
      check("leak_no_spike", spike_o, 0);
      step();
      check("leak_pos_2", pot(0), 0);
      drive(1'b1, -16'sd7, 16'h0001, 1'b0, 1'b0);
      step();
      check("leak_neg_1", pot(0), -2);
      step();
      check("leak_neg_2", pot(0), 0);
      idle();

      // Saturation both ways on neuron 3
      leak = '0;
      repeat (1000) drive(1'b1, 16'sh7FFF, 16'h0008, 1'b0, 1'b0);
      check("sat_pos", pot(3), 32767);
      check("sat_other", pot(2), 0);
      repeat (1000) drive(1'b1, -16'sd32768, 16'h0008, 1'b0, 1'b0);
      check("sat_neg", pot(3), -32768);
      pic();
      idle();

      // Refractory: two ignored timesteps, then integration resumes
      refrac_period = 4'd2;
      drive(1'b1, 16'sd100, 16'h0001, 1'b0, 1'b0);
      step();
      check("refr_fire", spike_o, 16'h0001);
      check("refr_cnt2", rfr(0), 2);
      drive(1'b1, 16'sd100, 16'h0001, 1'b0, 1'b0);
      check("refr_ignored1", pot(0), 0);
      step();
      check("refr_nospike1", spike_o, 0);
      check("refr_cnt1", rfr(0), 1);
      drive(1'b1, 16'sd100, 16'h0001, 1'b0, 1'b0);
      step();
      check("refr_nospike2", spike_o, 0);
      check("refr_cnt0", rfr(0), 0);
      drive(1'b1, 16'sd100, 16'h0001, 1'b0, 1'b0);
      check("refr_resume", pot(0), 100);
      step();
      check("refr_fire_again", spike_o, 16'h0001);
      pic();
      idle();

      // Winner with a tie between neurons 2 and 5
      refrac_period = 4'd0; threshold = 16'sd10;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 16'sd10, (k < 2) ? 16'h00A4 : 16'h0024, 1'b0, 1'b0);
         step();
      end
      check("win_cnt7", cnt(7), 2);
      pic();
      check("win_idx", winner_o, 2);
      check("win_valid", winner_valid, 1);
      check("win_cleared_cnt2", cnt(2), 0);
      idle();
      check("win_valid_drops", winner_valid, 0);
      pic();
      check("win_all_zero_idx", winner_o, 0);
      check("win_all_zero_valid", winner_valid, 1);
      idle();

      // step_done and picture_done together
      drive(1'b1, 16'sd50, 16'h0002, 1'b0, 1'b0);
      step();
      check("coll_pre_spike", spike_o, 16'h0002);
      drive(1'b1, 16'sd50, 16'h0002, 1'b0, 1'b0);
      drive(1'b0, 16'sd0, '0, 1'b1, 1'b1);
      check("coll_no_spike_valid", spike_valid, 0);
      check("coll_winner_valid", winner_valid, 1);
      check("coll_winner", winner_o, 1);
      idle();

      // Asynchronous reset mid-picture
      refrac_period = 4'd3;
      drive(1'b1, 16'sd50, 16'hFFFF, 1'b0, 1'b0);
      step();
      check("rst_pre_valid", spike_valid, 1);
      check("rst_pre_spike", spike_o, 16'hFFFF);
      #2 rst = 1'b1;
      #1;
      check("rst_spike_valid", spike_valid, 0);
      check("rst_spike_o", spike_o, 0);
      check("rst_winner_o", winner_o, 0);
      check("rst_winner_valid", winner_valid, 0);
      check("rst_refrac0", rfr(0), 0);
      check("rst_pot15", pot(15), 0);
      check("rst_cnt0", cnt(0), 0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
